// File: rtl/seg_scan_decoder.sv
// ----------------------------------------------------------------------------
// seg_scan_decoder
//
// Drives an 8-digit multiplexed seven-segment display from a 32-bit hex value.
// A divider holds each digit lit for SCAN_DIV clk cycles, then the scan index
// advances 0..7 and wraps. Display data is captured into shadow registers on
// a load strobe, so the image stays stable while the CPU keeps running.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   load       capture data/dp_in/digit_en into the shadow registers
//   data       32-bit value; digit i shows data[4i+3:4i], digit 0 rightmost
//   dp_in      per-digit decimal point request, active-high
//   digit_en   per-digit enable, 0 blanks that digit
//   an         anode select, active-low, at most one bit low
//   seg        segments, active-low, seg[0]=a .. seg[6]=g
//   dp         decimal point, active-low
//   frame_done one-cycle pulse when the scan wraps from digit 7 to digit 0
// ----------------------------------------------------------------------------
module seg_scan_decoder #(
   parameter int SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] data,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  digit_en,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   // A one-bit counter is kept even for SCAN_DIV=1; it simply stays at 0.
   localparam int               CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   localparam logic [7:0] AN_OFF  = 8'hFF;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   logic [CNT_W-1:0] div_cnt;
   logic [2:0]       idx;
   logic [31:0]      sh_data;
   logic [7:0]       sh_dp;
   logic [7:0]       sh_en;

   logic             tick;
   logic [3:0]       nibble;
   logic [6:0]       hex_seg;
   logic [7:0]       an_nxt;
   logic [6:0]       seg_nxt;
   logic             dp_nxt;

   assign tick = (div_cnt == CNT_MAX);

   // Scan divider and digit index. idx wraps 7 -> 0 naturally as a 3-bit value.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         idx     <= '0;
      end else if (tick) begin
         div_cnt <= '0;
         idx     <= idx + 3'd1;
      end else begin
         div_cnt <= div_cnt + CNT_W'(1);
      end
   end

   // Shadow registers. They are ordinary flops (not a RAM), so resetting them
   // is cheap and gives a defined blank-ish image ("00000000") after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_data <= '0;
         sh_dp   <= '0;
         sh_en   <= 8'hFF;
      end else if (load) begin
         sh_data <= data;
         sh_dp   <= dp_in;
         sh_en   <= digit_en;
      end
   end

   // Selected nibble of the currently scanned digit.
   assign nibble = 4'(sh_data >> {idx, 2'b00});

   // Hex to active-low segment pattern, bit order g..a.
   always_comb begin
      hex_seg = SEG_OFF;
      unique case (nibble)
         4'h0: hex_seg = 7'h40;
         4'h1: hex_seg = 7'h79;
         4'h2: hex_seg = 7'h24;
         4'h3: hex_seg = 7'h30;
         4'h4: hex_seg = 7'h19;
         4'h5: hex_seg = 7'h12;
         4'h6: hex_seg = 7'h02;
         4'h7: hex_seg = 7'h78;
         4'h8: hex_seg = 7'h00;
         4'h9: hex_seg = 7'h10;
         4'hA: hex_seg = 7'h08;
         4'hB: hex_seg = 7'h03;
         4'hC: hex_seg = 7'h46;
         4'hD: hex_seg = 7'h21;
         4'hE: hex_seg = 7'h06;
         4'hF: hex_seg = 7'h0E;
      endcase
   end

   // Next output image for the current digit; a disabled digit is fully dark.
   // NOTE: every combinational output gets a default before any branch so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      an_nxt  = AN_OFF;
      seg_nxt = SEG_OFF;
      dp_nxt  = 1'b1;
      if (sh_en[idx]) begin
         an_nxt  = ~(8'b1 << idx);
         seg_nxt = hex_seg;
         dp_nxt  = ~sh_dp[idx];
      end
   end

   // Registered outputs: one cycle behind idx and the shadows. frame_done
   // coincides with the first cycle idx reads 0 after a 7 -> 0 wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an         <= AN_OFF;
         seg        <= SEG_OFF;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         an         <= an_nxt;
         seg        <= seg_nxt;
         dp         <= dp_nxt;
         frame_done <= tick && (idx == 3'd7);
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_decoder
//
// Runs two copies of the decoder side by side (SCAN_DIV=4 and SCAN_DIV=1) on
// shared inputs. A reference model derives the expected display purely from
// the number of clock edges since reset and the last loaded image, and a
// monitor compares every output of both copies on every falling edge.
// ----------------------------------------------------------------------------
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [31:0] data;
   logic [7:0]  dp_in;
   logic [7:0]  digit_en;

   logic [7:0]  an4, an1;
   logic [6:0]  seg4, seg1;
   logic        dp4, dp1;
   logic        fd4, fd1;

   int          n_checks = 0;
   int          n_fail   = 0;
   bit          chk_en   = 1'b0;

   always #5 clk = ~clk;

   seg_scan_decoder #(.SCAN_DIV(4)) u_dut4 (
      .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in),
      .digit_en(digit_en), .an(an4), .seg(seg4), .dp(dp4), .frame_done(fd4)
   );

   seg_scan_decoder #(.SCAN_DIV(1)) u_dut1 (
      .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in),
      .digit_en(digit_en), .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [6:0]  hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   int          divs [2] = '{4, 1};

   int unsigned n_edge;   // clock edges seen since reset released
   logic [31:0] m_data;
   logic [7:0]  m_dp, m_en;
   logic [7:0]  exp_an  [2];
   logic [6:0]  exp_seg [2];
   logic        exp_dp  [2];
   logic        exp_fd  [2];

   always @(posedge clk or posedge rst) begin : model
      int d, i;
      if (rst) begin
         n_edge = 0;
         m_data = '0;
         m_dp   = '0;
         m_en   = 8'hFF;
         for (int k = 0; k < 2; k++) begin
            exp_an[k]  = 8'hFF;
            exp_seg[k] = 7'h7F;
            exp_dp[k]  = 1'b1;
            exp_fd[k]  = 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            d = divs[k];
            i = (n_edge / d) % 8;          // digit shown during the cycle before this edge
            if (m_en[i]) begin
               exp_an[k]  = ~(8'd1 << i);
               exp_seg[k] = hex_tbl[(m_data >> (4 * i)) & 32'hF];
               exp_dp[k]  = ~m_dp[i];
            end else begin
               exp_an[k]  = 8'hFF;
               exp_seg[k] = 7'h7F;
               exp_dp[k]  = 1'b1;
            end
            exp_fd[k] = ((n_edge + 1) % (8 * d)) == 0;
         end
         if (load) begin
            m_data = data;
            m_dp   = dp_in;
            m_en   = digit_en;
         end
         n_edge++;
      end
   end

   // ---------------- cycle monitor ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("an_div4",      an4,  exp_an[0]);
         check("seg_div4",     seg4, exp_seg[0]);
         check("dp_div4",      dp4,  exp_dp[0]);
         check("fdone_div4",   fd4,  exp_fd[0]);
         check("onehot_div4",  32'($countones(~an4) <= 1), 1);
         check("an_div1",      an1,  exp_an[1]);
         check("seg_div1",     seg1, exp_seg[1]);
         check("dp_div1",      dp1,  exp_dp[1]);
         check("fdone_div1",   fd1,  exp_fd[1]);
         check("onehot_div1",  32'($countones(~an1) <= 1), 1);
      end
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_img(input logic [31:0] d, input logic [7:0] dpv, input logic [7:0] en);
      @(negedge clk);
      load     = 1'b1;
      data     = d;
      dp_in    = dpv;
      digit_en = en;
      @(negedge clk);
      load     = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      int          budget;
      logic [31:0] r;

      rst      = 1'b1;
      load     = 1'b1;
      data     = 32'hFFFF_FFFF;
      dp_in    = 8'hFF;
      digit_en = 8'h00;

      // Reset with an ignored load.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_an",    an4,  8'hFF);
      check("rst_seg",   seg4, 7'h7F);
      check("rst_dp",    dp4,  1'b1);
      check("rst_fdone", fd4,  1'b0);
      rst    = 1'b0;
      load   = 1'b0;
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_an_div4",  an4,  8'hFE);
      check("post_rst_seg_div4", seg4, 7'h40);
      check("post_rst_an_div1",  an1,  8'hFE);
      check("post_rst_seg_div1", seg1, 7'h40);

      // Decode 8 on digit 0 and A on digit 1, then a full frame.
      load_img(32'h0000_00A8, 8'h00, 8'hFF);
      run(40);

      // Sweep all nibble values through digit 0, one full DIV=4 frame each.
      for (int v = 0; v < 16; v++) begin
         r = $urandom();
         load_img((r & 32'hFFFF_FFF0) | 32'(v), 8'h00, 8'hFF);
         run(32);
      end

      // Blanking and decimal points.
      load_img($urandom(), 8'h01, 8'h01);
      run(40);
      load_img($urandom(), 8'h02, 8'hFF);
      run(40);

      // Load coinciding with the tick into digit 0 (DIV=4).
      budget = 0;
      while (((n_edge + 1) % 32) != 0 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 100) check("timeout_collision", 0, 1);
      load     = 1'b1;
      data     = 32'h0000_0001;
      dp_in    = 8'h00;
      digit_en = 8'hFF;
      @(negedge clk);
      load = 1'b0;
      @(posedge clk);
      #1;
      check("collision_an",  an4,  8'hFE);
      check("collision_seg", seg4, 7'h79);
      run(40);

      // Randomized loads.
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         load     = ($urandom_range(3) == 0);
         data     = $urandom();
         dp_in    = 8'($urandom());
         digit_en = 8'($urandom());
      end
      @(negedge clk);
      load = 1'b0;
      load_img($urandom(), 8'h00, 8'hFF);

      // Asynchronous reset while digit 5 is showing on the DIV=4 copy.
      budget = 0;
      while (((n_edge / 4) % 8) != 5 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 100) check("timeout_idx5", 0, 1);
      run(1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_an_div4",  an4,  8'hFF);
      check("async_rst_seg_div4", seg4, 7'h7F);
      check("async_rst_an_div1",  an1,  8'hFF);
      check("async_rst_seg_div1", seg1, 7'h7F);
      run(2);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("restart_an_div4", an4, 8'hFE);
      check("restart_an_div1", an1, 8'hFE);
      run(80);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
